// File: rtl/mips_core_pkg.sv
// Shared core types and fetch-path constants.
package mips_core_pkg;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

  localparam int unsigned INSTRUCTION_QUEUE_DEPTH = 8;
  localparam int unsigned FETCH_MAX_OUTSTANDING   = 4;
  localparam logic [31:0] FETCH_RESET_PC          = 32'h0000_0000;

endpackage

// File: rtl/fetch_scheduler_if.sv
// Fetch scheduler <-> i-cache / instruction queue signal bundle.
interface fetch_scheduler_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_fwd_valid;
  logic        q_pop;
  logic        q_flush;
  logic        busy_draining;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  req_ready,
    input  resp_valid,
    input  q_pop,
    output req_valid,
    output req_pc,
    output resp_fwd_valid,
    output q_flush,
    output busy_draining
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    output req_ready,
    output resp_valid,
    output q_pop,
    input  req_valid,
    input  req_pc,
    input  resp_fwd_valid,
    input  q_flush,
    input  busy_draining
  );

endinterface

// File: rtl/fetch_credit_counter.sv
// Up/down counter with load; the next value is clamped to 0..MAX.
module fetch_credit_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 8,
  parameter int unsigned RST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [1:0]   up_i,
  input  logic [1:0]   dn_i,
  output logic [W-1:0] cnt_q_o,
  output logic [W-1:0] cnt_d_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W+1:0] sum;
  logic [W+1:0] dn_ext;
  logic [W+1:0] nxt;

  always_comb begin
    sum    = {2'b00, cnt_q} + {{W{1'b0}}, up_i};
    dn_ext = {{W{1'b0}}, dn_i};
    nxt    = '0;
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (sum < dn_ext) begin
      cnt_d = '0;
    end else begin
      nxt   = sum - dn_ext;
      cnt_d = (nxt > (W+2)'(MAX)) ? W'(MAX)
                                  : nxt[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= W'(RST);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_q_o = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/fetch_scheduler.sv
// Credit-based fetch sequencer with redirect flush and stale-response squash.
// Optional perf counters enabled by defining FETCH_SCHED_PERF_EN.
module fetch_scheduler
  import mips_core_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = INSTRUCTION_QUEUE_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [31:0] RESET_PC        = FETCH_RESET_PC
) (
  input logic clk,
  input logic rst_n,
  fetch_scheduler_if.master bus
`ifdef FETCH_SCHED_PERF_EN
  ,
  output logic [31:0] perf_credit_stall,
  output logic [31:0] perf_squashed,
  output logic [31:0] perf_redirects
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [IW-1:0] MAXO_C  = IW'(MAX_OUTSTANDING);

  fetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [IW-1:0] sq_q, sq_d;
  logic [CW-1:0] cred_q, cred_d, cred_ld;
  logic [IW-1:0] infl_q, infl_d;
  logic [1:0]    cred_up, cred_dn;
  logic [1:0]    infl_up, infl_dn;
  logic          redir, resp, issue, accept;
  logic          squash, fwd, pop;

  // Everything is gated by rst_n so the reset cycle is quiet.
  always_comb begin
    redir  = rst_n & bus.redirect_valid;
    resp   = rst_n & bus.resp_valid;
    issue  = rst_n && (state_q == FETCH) && !redir
             && (cred_q != '0) && (infl_q < MAXO_C);
    accept = issue & bus.req_ready;
    squash = resp & (redir | (sq_q != '0));
    fwd    = resp & ~squash;
    pop    = rst_n & bus.q_pop & ~redir;
  end

  always_comb begin
    cred_up = {1'b0, squash} + {1'b0, pop};
    cred_dn = {1'b0, accept};
    infl_up = {1'b0, accept};
    infl_dn = {1'b0, resp};
    cred_ld = DEPTH_C - CW'(infl_d);
  end

  fetch_credit_counter #(
    .W   (CW),
    .MAX (QUEUE_DEPTH),
    .RST (QUEUE_DEPTH)
  ) u_credits (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (redir),
    .load_val_i (cred_ld),
    .up_i       (cred_up),
    .dn_i       (cred_dn),
    .cnt_q_o    (cred_q),
    .cnt_d_o    (cred_d)
  );

  fetch_credit_counter #(
    .W   (IW),
    .MAX (MAX_OUTSTANDING),
    .RST (0)
  ) u_inflight (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .up_i       (infl_up),
    .dn_i       (infl_dn),
    .cnt_q_o    (infl_q),
    .cnt_d_o    (infl_d)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sq_d    = sq_q;
    unique case (1'b1)
      redir: begin
        sq_d    = infl_d;
        pc_d    = bus.redirect_pc;
        state_d = (infl_d != '0) ? DRAIN : FETCH;
      end
      default: begin
        if (squash) sq_d = sq_q - IW'(1);
        if (accept) pc_d = pc_q + 32'd4;
        if (state_q == DRAIN && sq_d == '0)
          state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sq_q    <= sq_d;
    end
  end

  assign bus.req_valid      = issue;
  assign bus.req_pc         = pc_q;
  assign bus.q_flush        = redir;
  assign bus.resp_fwd_valid = fwd;
  assign bus.busy_draining  = rst_n && (state_q == DRAIN);

  a_resp_inflight: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.resp_valid |-> (infl_q != '0));

  a_cred_max: assert property (
    @(posedge clk) disable iff (!rst_n)
    (cred_q <= DEPTH_C) && (cred_d <= DEPTH_C));

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] pstall_q, psq_q, predir_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstall_q <= '0;
      psq_q    <= '0;
      predir_q <= '0;
    end else begin
      if (state_q == FETCH && cred_q == '0
          && pstall_q != '1)
        pstall_q <= pstall_q + 32'd1;
      if (squash && psq_q != '1)
        psq_q <= psq_q + 32'd1;
      if (redir && predir_q != '1)
        predir_q <= predir_q + 32'd1;
    end
  end

  assign perf_credit_stall = pstall_q;
  assign perf_squashed     = psq_q;
  assign perf_redirects    = predir_q;
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: directed table plus randomized model.
module tb_fetch_scheduler;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_scheduler_if bus();

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] p_stall, p_sq, p_redir;
`endif

  fetch_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_SCHED_PERF_EN
    ,
    .perf_credit_stall (p_stall),
    .perf_squashed     (p_sq),
    .perf_redirects    (p_redir)
`endif
  );

  typedef struct {
    bit stale;
    int due;
  } fl_t;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          rsp;
    bit          pop;
    bit          erv;
    logic [31:0] epc;
    bit          efl;
    bit          efwd;
    bit          ebusy;
  } vec_t;

  fl_t         fl[$];
  int          occ;
  logic [31:0] mpc;
  int          cyc;
  int          checks;
  int          failures;
  bit          s_rv;
  bit          s_acc;
  logic [31:0] s_pc;
  int          lat_lo = 1;
  int          lat_hi = 1;
  vec_t        nv;
  vec_t        tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic bit any_stale();
    foreach (fl[i]) if (fl[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rv, input logic [31:0] rpc,
                      input bit rdy, input bit rsp_i, input bit pp_i,
                      input bit use_v, input vec_t v);
    bit  rsp, pp, st, m_rv, m_fwd;
    int  cred;
    fl_t e;
    rsp = rsp_i && (fl.size() > 0);
    pp  = pp_i && (occ > 0);
    @(negedge clk);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.req_ready      = rdy;
    bus.resp_valid     = rsp;
    bus.q_pop          = pp;
    #1;
    st    = any_stale();
    cred  = DEPTH - fl.size() - occ;
    m_rv  = !st && !rv && cred > 0 && fl.size() < MAXO;
    m_fwd = rsp && !rv && !fl[0].stale;
    if (use_v) begin
      chk("tbl_req_valid", 32'(bus.req_valid), 32'(v.erv));
      if (v.erv) chk("tbl_req_pc", bus.req_pc, v.epc);
      chk("tbl_q_flush", 32'(bus.q_flush), 32'(v.efl));
      chk("tbl_fwd", 32'(bus.resp_fwd_valid), 32'(v.efwd));
      chk("tbl_busy", 32'(bus.busy_draining), 32'(v.ebusy));
    end else begin
      chk("req_valid", 32'(bus.req_valid), 32'(m_rv));
      if (m_rv) chk("req_pc", bus.req_pc, mpc);
      chk("q_flush", 32'(bus.q_flush), 32'(rv));
      chk("fwd", 32'(bus.resp_fwd_valid), 32'(m_fwd));
      chk("busy", 32'(bus.busy_draining), 32'(st));
    end
    s_rv  = bus.req_valid;
    s_pc  = bus.req_pc;
    s_acc = bus.req_valid && rdy;
    @(posedge clk);
    if (rsp) void'(fl.pop_front());
    if (m_fwd) occ++;
    if (rv) begin
      foreach (fl[i]) fl[i].stale = 1'b1;
      occ = 0;
      mpc = rpc;
    end else begin
      if (pp) occ--;
      if (m_rv && rdy) begin
        e.stale = 1'b0;
        e.due   = cyc + $urandom_range(lat_lo, lat_hi);
        fl.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic cm(input bit rv, input logic [31:0] rpc,
                    input bit rdy, input bit rsp, input bit pp);
    step(rv, rpc, rdy, rsp, pp, 1'b0, nv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hdead_beec;
    bus.req_ready      = 1'b1;
    bus.resp_valid     = 1'b0;
    bus.q_pop          = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.req_valid), 0);
    chk("rst_q_flush", 32'(bus.q_flush), 0);
    chk("rst_fwd", 32'(bus.resp_fwd_valid), 0);
    chk("rst_busy", 32'(bus.busy_draining), 0);
    @(negedge clk);
    #1;
    chk("rst2_req_valid", 32'(bus.req_valid), 0);
    chk("rst2_q_flush", 32'(bus.q_flush), 0);
    fl.delete();
    occ = 0;
    mpc = 32'h0;
    @(posedge clk);
    #1;
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
  endtask

  function automatic vec_t mk(bit rv, logic [31:0] rpc, bit rdy,
                              bit rsp, bit pop, bit erv,
                              logic [31:0] epc, bit efl,
                              bit efwd, bit ebusy);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.pop = pop;
    v.erv = erv; v.epc = epc; v.efl = efl; v.efwd = efwd;
    v.ebusy = ebusy;
    return v;
  endfunction

  initial begin
    int acc;
    bit rv, rdy, rsp, pp;
    logic [31:0] rpc;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    occ      = 0;
    mpc      = 32'h0;
    nv       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.q_pop          = 1'b0;

    tbl[0]  = mk(0, 32'h0,    1, 0, 0, 1, 32'h0,    0, 0, 0);
    tbl[1]  = mk(0, 32'h0,    1, 0, 0, 1, 32'h4,    0, 0, 0);
    tbl[2]  = mk(0, 32'h0,    1, 0, 0, 1, 32'h8,    0, 0, 0);
    tbl[3]  = mk(1, 32'h1000, 1, 0, 0, 0, 32'h0,    1, 0, 0);
    tbl[4]  = mk(0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 1);
    tbl[5]  = mk(0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 1);
    tbl[6]  = mk(0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 1);
    tbl[7]  = mk(0, 32'h0,    0, 0, 0, 1, 32'h1000, 0, 0, 0);
    tbl[8]  = mk(0, 32'h0,    1, 0, 0, 1, 32'h1000, 0, 0, 0);
    tbl[9]  = mk(0, 32'h0,    1, 1, 0, 1, 32'h1004, 0, 1, 0);
    tbl[10] = mk(0, 32'h0,    1, 0, 0, 1, 32'h1008, 0, 0, 0);
    tbl[11] = mk(1, 32'h3000, 1, 1, 1, 0, 32'h0,    1, 0, 0);
    tbl[12] = mk(0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 1);
    tbl[13] = mk(0, 32'h0,    1, 0, 0, 1, 32'h3000, 0, 0, 0);
    tbl[14] = mk(1, 32'h5000, 1, 0, 0, 0, 32'h0,    1, 0, 0);
    tbl[15] = mk(1, 32'h2000, 1, 0, 0, 0, 32'h0,    1, 0, 1);
    tbl[16] = mk(0, 32'h0,    1, 1, 0, 0, 32'h0,    0, 0, 1);
    tbl[17] = mk(0, 32'h0,    1, 0, 0, 1, 32'h2000, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 18; i++)
      step(tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].rsp,
           tbl[i].pop, 1'b1, tbl[i]);

    // Credit exhaustion: eight accepts, then one pop re-enables issue.
    do_reset();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      cm(0, 0, 1, 1, 0);
      if (s_acc) acc++;
    end
    chk("t1_accepts", 32'(acc), 32'd8);
    chk("t1_stalled", 32'(s_rv), 0);
    cm(0, 0, 1, 0, 1);
    chk("t1_pop_cycle", 32'(s_rv), 0);
    cm(0, 0, 1, 1, 0);
    chk("t1_reissue_valid", 32'(s_rv), 1);
    chk("t1_reissue_pc", s_pc, 32'h20);

    // Hold request address while the i-cache is not ready.
    cm(1, 32'h40, 1, 1, 0);
    for (int i = 0; i < 10 && fl.size() > 0; i++) cm(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cm(0, 0, 0, 0, 0);
      chk("t2_hold_valid", 32'(s_rv), 1);
      chk("t2_hold_pc", s_pc, 32'h40);
    end
    cm(0, 0, 1, 0, 0);
    chk("t2_accept", 32'(s_acc), 1);
    cm(0, 0, 0, 0, 0);
    chk("t2_next_pc", s_pc, 32'h44);

    // Outstanding limit with slow responses.
    do_reset();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cm(0, 0, 1, 0, 0);
      if (s_acc) acc++;
    end
    chk("t6_accepts", 32'(acc), 32'd4);
    chk("t6_stalled", 32'(s_rv), 0);
    cm(0, 0, 1, 1, 0);
    chk("t6_resp_cycle", 32'(s_rv), 0);
    cm(0, 0, 1, 0, 0);
    chk("t6_resume", 32'(s_rv), 1);

    // Randomized traffic against the model.
    lat_lo = 1;
    lat_hi = 6;
    for (int i = 0; i < 1500; i++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0;
      rdy = ($urandom_range(0, 3) != 0);
      rsp = (fl.size() > 0) && (fl[0].due <= cyc);
      pp  = ($urandom_range(0, 1) == 1);
      cm(rv, rpc, rdy, rsp, pp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
